pipe_skid: RTL and testbench
============================

# pipe_skid

Two-entry elastic pipeline register (skid buffer) with valid/ready handshakes on both sides and a synchronous flush. It sits directly in front of a `dff`-based pipeline stage register. It consumes the upstream stage's output and lets the downstream stage stall without a combinational ready path crossing the stage boundary. Storage is built from two instances of the existing `dff` block.

## Interface
Parameters:
- `width_p`, 32, payload width in bits
- `reset_val_p`, 0, value held in both storage registers and driven on `data_o` after reset

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `flush_i`  in  1  synchronous flush; discards all buffered entries
- `v_i`  in  1  upstream valid
- `data_i`  in  `width_p`  upstream payload
- `ready_o`  out  1  buffer can accept; a pure function of registered state
- `v_o`  out  1  downstream valid
- `data_o`  out  `width_p`  downstream payload, always driven from the main register
- `ready_i`  in  1  downstream ready
- `count_o`  out  2  occupancy, 0..2

## Operation
- Transfer in: `v_i & ready_o`. Transfer out: `v_o & ready_i`.
- State (`pipe_skid_state_e`) takes one of three values:
  - EMPTY: count 0.
  - BUSY: main register valid, count 1.
  - FULL: main and skid registers valid, count 2.
- Outputs by state:
  - `v_o = (state != EMPTY)`
  - `ready_o = (state != FULL)`
  - `count_o` = occupancy as listed above
- EMPTY:
  - In-transfer: main <= `data_i`, go to BUSY.
  - Otherwise: stay in EMPTY.
- BUSY:
  - In and out together: main <= `data_i`, stay in BUSY.
  - In only: skid <= `data_i`, go to FULL.
  - Out only: go to EMPTY.
  - Neither: hold.
- FULL:
  - Out-transfer: main <= skid, go to BUSY.
  - Otherwise: hold.
  - `v_i` is ignored because `ready_o` is 0.
- `flush_i`:
  - Next state is EMPTY from any state, and flush takes priority over every transfer.
  - A same-cycle in-transfer is dropped.
  - A same-cycle out-transfer is still counted as consumed by downstream.
  - Register contents are not cleared.
- Ordering: strict FIFO; the skid entry never overtakes the main entry.
- Data registers load only on the write enables above. `data_o` is stable while `v_o & ~ready_i`.

## Timing
- Reset (`rst_ni` low, asynchronous), immediately and for as long as it is held:
  - state EMPTY, `v_o`=0, `ready_o`=1, `count_o`=0, `data_o`=`reset_val_p`, skid=`reset_val_p`.
  - No transfer is recorded while in reset.
- Latency: a word accepted in cycle N appears on `data_o` with `v_o`=1 in cycle N+1 when the buffer was EMPTY, or when it was BUSY with a same-cycle out-transfer.
- Throughput: one word per cycle sustained while `ready_i`=1.
- `ready_o` and `v_o` are registered-state functions. There is no combinational path from `ready_i` to `ready_o`, or from `v_i` to `v_o`.
- After FULL, `ready_o` returns to 1 in the cycle after the first out-transfer.
- Reset mid-operation drops all entries. The first in-transfer after `rst_ni` rises is accepted normally.

## Structure
- Shared package `pipe_pkg`:
  - `pipe_skid_state_e` (EMPTY, BUSY, FULL; 2-bit encoding)
  - count-width localparam
- Sub-module: two instances of `dff`, used as the main and skid registers.
  - `w_v_i` is driven from the load enables.
  - `reset_val_p` is passed through.
  - Its reset input is driven from the inverted `rst_ni`, so reset stays asynchronous at the instance.
- The state register is local to `pipe_skid`. Next-state and enable logic is one combinational block.

## Test plan
- Reset: hold `rst_ni`=0 with `v_i`=1, `data_i`=0xAAAA -> `v_o`=0, `ready_o`=1, `count_o`=0, `data_o`=`reset_val_p`. After release, the first transfer 0x1111 appears the next cycle.
- Streaming: `ready_i`=1, inputs 0x1, 0x2, 0x3 on consecutive cycles -> `data_o` is 0x1, 0x2, 0x3 on the next three cycles, `count_o` stays 1.
- Backpressure: `ready_i`=0, send 0xA then 0xB -> `count_o`=2 and `ready_o`=0. A third input 0xC held on `v_i` is not accepted. Raising `ready_i` yields 0xA, 0xB, then 0xC, in order.
- Flush: FULL holding 0x5, 0x6, then `flush_i`=1 with `v_i`=1, `data_i`=0x7 -> the next cycle shows `v_o`=0, `count_o`=0, and 0x7 never appears on `data_o`.
- Mid-operation reset: FULL, pulse `rst_ni` low between clock edges -> outputs take their reset values immediately, without waiting for a clock edge.
- Random soak: random `v_i`/`ready_i`/`data_i` against a scoreboard queue for 10k cycles -> every output matches the queue head, and there is no loss or duplication.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipe_skid elastic buffer.
//   pipe_skid_state_e : occupancy state of the two-entry buffer
//   count_width_lp    : width of the occupancy count output
package pipe_pkg;

    localparam int unsigned count_width_lp = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_e;

    // Occupancy implied by a state.
    function automatic logic [count_width_lp-1:0] state_count(input pipe_skid_state_e s);
        case (s)
            EMPTY:   state_count = count_width_lp'(0);
            BUSY:    state_count = count_width_lp'(1);
            FULL:    state_count = count_width_lp'(2);
            default: state_count = count_width_lp'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_dff.sv
// dff: width_p-bit storage register with load enable and asynchronous,
// active-high reset to reset_val_p.
//   clk_i   : clock
//   reset_i : asynchronous reset, active high
//   w_v_i   : load enable
//   data_i  : value to load
//   data_o  : stored value
module dff #(
    parameter int unsigned        width_p     = 32,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               w_v_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // Storage register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= reset_val_p;
        end else if (w_v_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry skid buffer with valid/ready on both sides and a
// synchronous flush. ready_o and v_o decode only the state register, so no
// combinational path crosses the stage boundary.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   flush_i           : discard all buffered entries (wins over transfers)
//   v_i, data_i       : upstream valid and payload
//   ready_o           : buffer can accept
//   v_o, data_o       : downstream valid and payload (from main register)
//   ready_i           : downstream ready
//   count_o           : occupancy 0..2
module pipe_skid
    import pipe_pkg::*;
#(
    parameter int unsigned        width_p     = 32,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      ready_i,
    output logic [count_width_lp-1:0] count_o
);

    pipe_skid_state_e   state_q, state_n;
    logic               main_we, skid_we, main_from_skid;
    logic               in_xfer, out_xfer;
    logic [width_p-1:0] main_d, skid_q;

    // Handshake outputs decode the registered state only.
    assign v_o      = (state_q != EMPTY);
    assign ready_o  = (state_q != FULL);
    assign count_o  = state_count(state_q);

    assign in_xfer  = v_i & ready_o;
    assign out_xfer = v_o & ready_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and register load enables.
    always_comb begin
        state_n        = state_q;
        main_we        = 1'b0;
        skid_we        = 1'b0;
        main_from_skid = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_we = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_we = 1'b1;
                end else if (in_xfer) begin
                    skid_we = 1'b1;
                    state_n = FULL;
                end else if (out_xfer) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                // The skid entry moves up only once the main entry leaves.
                if (out_xfer) begin
                    main_we        = 1'b1;
                    main_from_skid = 1'b1;
                    state_n        = BUSY;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase

        // Flush drops everything, including a same-cycle in-transfer; the
        // registers keep their contents.
        if (flush_i) begin
            state_n = EMPTY;
            main_we = 1'b0;
            skid_we = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : data_i;

    // Main register: head of the FIFO, always drives data_o.
    dff #(
        .width_p    (width_p),
        .reset_val_p(reset_val_p)
    ) u_main (
        .clk_i  (clk_i),
        .reset_i(~rst_ni),
        .w_v_i  (main_we),
        .data_i (main_d),
        .data_o (data_o)
    );

    // Skid register: second entry, captured while downstream stalls.
    dff #(
        .width_p    (width_p),
        .reset_val_p(reset_val_p)
    ) u_skid (
        .clk_i  (clk_i),
        .reset_i(~rst_ni),
        .w_v_i  (skid_we),
        .data_i (data_i),
        .data_o (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid.sv
// Testbench for pipe_skid: queue-based reference model compared every
// negedge, directed scenarios with literal expectations, then a random soak.
module tb_pipe_skid;

    localparam int unsigned        w_lp     = 16;
    localparam logic [w_lp-1:0]    rst_v_lp = 16'h5A5A;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            v_i;
    logic [w_lp-1:0] data_i;
    logic            ready_o;
    logic            v_o;
    logic [w_lp-1:0] data_o;
    logic            ready_i;
    logic [1:0]      count_o;

    int errors = 0;
    int checks = 0;

    logic [w_lp-1:0] mq[$];

    pipe_skid #(
        .width_p    (w_lp),
        .reset_val_p(rst_v_lp)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .v_i    (v_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .v_o    (v_o),
        .data_o (data_o),
        .ready_i(ready_i),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two words.
    always @(posedge clk) begin
        if (rst_ni) begin
            automatic bit acc  = v_i && (mq.size() < 2);
            automatic bit take = (mq.size() > 0) && ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (take) void'(mq.pop_front());
                if (acc)  mq.push_back(data_i);
            end
        end
    end

    always @(negedge rst_ni) mq.delete();

    // Compare DUT against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_ni) begin
            check("m_v_o",     32'(v_o),     32'(mq.size() > 0));
            check("m_ready_o", 32'(ready_o), 32'(mq.size() < 2));
            check("m_count_o", 32'(count_o), 32'(mq.size()));
            if (mq.size() > 0) check("m_data_o", 32'(data_o), 32'(mq[0]));
        end
    end

    // Inputs set at negedge, sampled at posedge, result visible next negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_ni = 1'b1; flush_i = 1'b0; v_i = 1'b0; ready_i = 1'b0; data_i = '0;
        #1 rst_ni = 1'b0;

        // Reset held with upstream pushing.
        v_i = 1'b1; data_i = 16'hAAAA;
        @(negedge clk); cyc(); cyc();
        check("rst_v_o",     32'(v_o),     32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_count_o", 32'(count_o), 32'd0);
        check("rst_data_o",  32'(data_o),  32'h5A5A);
        rst_ni = 1'b1;

        // First transfer after release.
        data_i = 16'h1111; ready_i = 1'b1;
        cyc();
        check("first_v_o",  32'(v_o),    32'd1);
        check("first_data", 32'(data_o), 32'h1111);

        // Streaming.
        for (int i = 1; i <= 3; i++) begin
            data_i = w_lp'(i);
            cyc();
            check("stream_data",  32'(data_o),  32'(i));
            check("stream_count", 32'(count_o), 32'd1);
        end
        v_i = 1'b0;
        cyc();
        check("drain_v_o", 32'(v_o), 32'd0);

        // Backpressure.
        ready_i = 1'b0; v_i = 1'b1; data_i = 16'h000A;
        cyc();
        data_i = 16'h000B;
        cyc();
        check("bp_count",   32'(count_o), 32'd2);
        check("bp_ready_o", 32'(ready_o), 32'd0);
        data_i = 16'h000C;
        cyc();
        check("bp_hold_data",  32'(data_o),  32'h000A);
        check("bp_hold_count", 32'(count_o), 32'd2);
        ready_i = 1'b1;
        cyc();
        check("bp_out_b",   32'(data_o),  32'h000B);
        check("bp_count_1", 32'(count_o), 32'd1);
        cyc();
        check("bp_out_c", 32'(data_o), 32'h000C);
        v_i = 1'b0;
        cyc();
        check("bp_empty", 32'(v_o), 32'd0);

        // Flush while FULL with a same-cycle push.
        ready_i = 1'b0; v_i = 1'b1; data_i = 16'h0005;
        cyc();
        data_i = 16'h0006;
        cyc();
        check("fl_full", 32'(count_o), 32'd2);
        flush_i = 1'b1; data_i = 16'h0007;
        cyc();
        check("fl_v_o",     32'(v_o),     32'd0);
        check("fl_count",   32'(count_o), 32'd0);
        check("fl_ready_o", 32'(ready_o), 32'd1);
        flush_i = 1'b0; v_i = 1'b0; ready_i = 1'b1;
        cyc();
        check("fl_kept_main", 32'(data_o), 32'h0005);

        // Asynchronous reset pulse between edges while FULL.
        ready_i = 1'b0; v_i = 1'b1; data_i = 16'h0008;
        cyc();
        data_i = 16'h0009;
        cyc();
        v_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("ar_v_o",     32'(v_o),     32'd0);
        check("ar_ready_o", 32'(ready_o), 32'd1);
        check("ar_count",   32'(count_o), 32'd0);
        check("ar_data",    32'(data_o),  32'h5A5A);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        v_i = 1'b1; ready_i = 1'b1; data_i = 16'h1234;
        cyc();
        check("ar_first", 32'(data_o), 32'h1234);

        // Random soak.
        for (int n = 0; n < 10000; n++) begin
            v_i     = ($urandom_range(3) != 0);
            ready_i = ($urandom_range(2) != 0);
            flush_i = ($urandom_range(31) == 0);
            data_i  = w_lp'($urandom);
            cyc();
        end
        v_i = 1'b0; flush_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
